// File: rtl/hotspot_frame_ctrl.sv
// Frame controller for a streaming hotspot stencil kernel: joins temperature and
// power streams, forwards kernel results with per-frame framing, and sequences a job.
module hotspot_frame_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 512,
  parameter int COLS       = 512,
  parameter int LANES      = 4
) (
  input  logic                        aclk,
  input  logic                        axi_resetn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [15:0]                 num_frames,
  input  logic [DATA_WIDTH-1:0]       s_axis_temp_data,
  input  logic                        s_axis_temp_valid,
  output logic                        s_axis_temp_ready,
  input  logic [DATA_WIDTH-1:0]       s_axis_power_data,
  input  logic                        s_axis_power_valid,
  output logic                        s_axis_power_ready,
  output logic [2*DATA_WIDTH-1:0]     m_axis_join_data,
  output logic                        m_axis_join_valid,
  input  logic                        m_axis_join_ready,
  input  logic [DATA_WIDTH*LANES-1:0] s_axis_result_data,
  input  logic                        s_axis_result_valid,
  output logic                        s_axis_result_ready,
  output logic [DATA_WIDTH*LANES-1:0] m_axis_result_data,
  output logic                        m_axis_result_valid,
  input  logic                        m_axis_result_ready,
  output logic                        m_axis_result_last,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 frame_count
);

  localparam int FRAME_ELEMS = ROWS * COLS;
  localparam int FRAME_BEATS = FRAME_ELEMS / LANES;
  localparam int EW = (FRAME_ELEMS > 1) ? $clog2(FRAME_ELEMS) : 1;
  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [EW-1:0] ELEM_MAX = EW'(FRAME_ELEMS - 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(FRAME_BEATS - 1);

  generate
    if ((FRAME_ELEMS % LANES) != 0) begin : g_lanes_check
      $error("hotspot_frame_ctrl: ROWS*COLS must be divisible by LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [15:0]     num_frames_r;
  logic [15:0]     in_frame_r;
  logic [15:0]     frame_count_r;
  logic [EW-1:0]   in_elem_r;
  logic [BW-1:0]   out_beat_r;

  logic run_s, active_s, in_active_s, join_en_s, join_fire_s, res_fire_s;
  logic elem_wrap_s, beat_wrap_s, in_done_s, out_done_s;

  assign run_s       = (state_r == ST_RUN);
  assign active_s    = run_s | (state_r == ST_DRAIN);
  assign in_active_s = (in_frame_r != num_frames_r);
  assign join_en_s   = run_s & in_active_s;

  // Each side is ready only when the other side is valid, so words are consumed in pairs.
  assign m_axis_join_valid  = join_en_s & s_axis_temp_valid & s_axis_power_valid;
  assign s_axis_temp_ready  = join_en_s & m_axis_join_ready & s_axis_power_valid;
  assign s_axis_power_ready = join_en_s & m_axis_join_ready & s_axis_temp_valid;
  assign m_axis_join_data   = {s_axis_power_data, s_axis_temp_data};
  assign join_fire_s        = m_axis_join_valid & m_axis_join_ready;

  assign m_axis_result_valid = s_axis_result_valid & active_s;
  assign s_axis_result_ready = m_axis_result_ready & active_s;
  assign m_axis_result_data  = s_axis_result_data;
  assign res_fire_s          = m_axis_result_valid & m_axis_result_ready;

  assign elem_wrap_s        = (in_elem_r == ELEM_MAX);
  assign beat_wrap_s        = (out_beat_r == BEAT_MAX);
  assign m_axis_result_last = m_axis_result_valid & beat_wrap_s;
  assign in_done_s  = join_fire_s & elem_wrap_s & (in_frame_r == num_frames_r - 16'd1);
  assign out_done_s = res_fire_s & beat_wrap_s & (frame_count_r == num_frames_r - 16'd1);

  assign busy        = active_s;
  assign done        = (state_r == ST_DONE);
  assign frame_count = frame_count_r;

  // State register.
  always_ff @(posedge aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort overrides every transition, result completion beats input completion.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (num_frames != 16'd0) begin
              state_s = ST_RUN;
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (out_done_s) begin
            state_s = ST_DONE;
          end else if (in_done_s) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (out_done_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Job parameters plus input element/frame and result beat/frame counters.
  always_ff @(posedge aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      num_frames_r  <= 16'd0;
      in_frame_r    <= 16'd0;
      frame_count_r <= 16'd0;
      in_elem_r     <= '0;
      out_beat_r    <= '0;
    end else if (abort) begin
      in_elem_r  <= '0;
      in_frame_r <= 16'd0;
      out_beat_r <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      num_frames_r  <= num_frames;
      in_frame_r    <= 16'd0;
      frame_count_r <= 16'd0;
      in_elem_r     <= '0;
      out_beat_r    <= '0;
    end else begin
      if (join_fire_s) begin
        if (elem_wrap_s) begin
          in_elem_r  <= '0;
          in_frame_r <= in_frame_r + 16'd1;
        end else begin
          in_elem_r <= in_elem_r + EW'(1'b1);
        end
      end
      if (res_fire_s) begin
        if (beat_wrap_s) begin
          out_beat_r    <= '0;
          frame_count_r <= frame_count_r + 16'd1;
        end else begin
          out_beat_r <= out_beat_r + BW'(1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hotspot_frame_ctrl.sv
// Scoreboard bench for hotspot_frame_ctrl on a 4x4 grid with 4 lanes:
// 16 joins and 4 result beats per frame.
module tb_hotspot_frame_ctrl;

  logic        aclk, axi_resetn, start, abort;
  logic [15:0] num_frames;
  logic [7:0]  t_data, p_data;
  logic        t_valid, t_ready, p_valid, p_ready;
  logic [15:0] j_data;
  logic        j_valid, j_ready;
  logic [31:0] sr_data, mr_data;
  logic        sr_valid, sr_ready, mr_valid, mr_ready, mr_last;
  logic        busy, done;
  logic [15:0] frame_count;

  hotspot_frame_ctrl #(.DATA_WIDTH(8), .ROWS(4), .COLS(4), .LANES(4)) dut (
    .aclk(aclk), .axi_resetn(axi_resetn), .start(start), .abort(abort), .num_frames(num_frames),
    .s_axis_temp_data(t_data), .s_axis_temp_valid(t_valid), .s_axis_temp_ready(t_ready),
    .s_axis_power_data(p_data), .s_axis_power_valid(p_valid), .s_axis_power_ready(p_ready),
    .m_axis_join_data(j_data), .m_axis_join_valid(j_valid), .m_axis_join_ready(j_ready),
    .s_axis_result_data(sr_data), .s_axis_result_valid(sr_valid), .s_axis_result_ready(sr_ready),
    .m_axis_result_data(mr_data), .m_axis_result_valid(mr_valid), .m_axis_result_ready(mr_ready),
    .m_axis_result_last(mr_last), .busy(busy), .done(done), .frame_count(frame_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0, n_err = 0;
  logic [15:0] join_q[$];
  logic [32:0] res_q[$];
  int t_idx, p_idx, jc, pc, r_idx, cyc_n;
  int exp_fc, done_cnt, done_cnt0, last_beat_cyc, done_cyc;
  int stall_beat = -1, stall_left = 0;
  bit src_on, pw_toggle, pw_check, stall_check, hold_rready0, pending_fc;
  logic snap_busy, snap_done, snap_rdy, snap_vld;
  logic [15:0] snap_fc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] beat_word(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {b, ~b, b + 8'h10, 8'h5A};
  endfunction

  task automatic drive();
    t_data  = t_idx[7:0];
    p_data  = p_idx[7:0] ^ 8'hA5;
    t_valid = src_on;
    p_valid = src_on & (pw_toggle ? cyc_n[0] : 1'b1);
    j_ready = 1'b1;
    sr_valid = ((r_idx + 1) * 4 <= jc);
    sr_data  = beat_word(r_idx);
    if (hold_rready0) begin
      mr_ready = 1'b0;
    end else if (stall_beat >= 0 && r_idx == stall_beat && stall_left > 0) begin
      mr_ready = 1'b0;
      stall_left--;
    end else begin
      mr_ready = 1'b1;
    end
  endtask

  task automatic step();
    logic tf, pf, jf, rf;
    @(negedge aclk);
    cyc_n++;
    tf = t_valid & t_ready;
    pf = p_valid & p_ready;
    jf = j_valid & j_ready;
    rf = sr_valid & sr_ready;
    snap_busy = busy; snap_done = done; snap_fc = frame_count;
    snap_rdy  = t_ready | p_ready | sr_ready;
    snap_vld  = j_valid | mr_valid;
    if (mr_valid && mr_ready && mr_last) last_beat_cyc = cyc_n;
    if (done) done_cyc = cyc_n;
    @(posedge aclk); #1;
    start = 1'b0; abort = 1'b0;
    if (tf) t_idx++;
    if (pf) begin p_idx++; pc++; end
    if (jf) jc++;
    if (rf) r_idx++;
    drive();
  endtask

  task automatic start_job(input int nf);
    t_idx = 0; p_idx = 0; jc = 0; pc = 0; r_idx = 0;
    exp_fc = 0; pending_fc = 1'b0; done_cnt0 = done_cnt;
    for (int k = 0; k < nf * 16; k++) join_q.push_back({8'(k) ^ 8'hA5, 8'(k)});
    for (int k = 0; k < nf * 4; k++) res_q.push_back({(k % 4 == 3), beat_word(k)});
    num_frames = 16'(nf);
    start = 1'b1;
    drive();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    done_cyc = -1;
    while (done_cyc < 0 && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", (done_cyc >= 0), 1'b1);
  endtask

  task automatic end_job_checks(input string tag, input int nf);
    step();
    chk({tag, "_done_width"}, snap_done, 1'b0);
    chk({tag, "_busy_low"}, snap_busy, 1'b0);
    chk({tag, "_frame_count"}, snap_fc, 16'(nf));
    chk({tag, "_joins"}, jc, nf * 16);
    chk({tag, "_beats"}, r_idx, nf * 4);
    chk({tag, "_queues_empty"}, join_q.size() + res_q.size(), 0);
    chk({tag, "_done_pulses"}, done_cnt - done_cnt0, 1);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks invariants.
  initial begin
    forever begin
      @(negedge aclk);
      if (axi_resetn) begin
        if (j_valid && j_ready) begin
          if (join_q.size() == 0) chk("join_unexpected", 1'b1, 1'b0);
          else chk("join_data", j_data, join_q.pop_front());
        end
        if (pending_fc) begin
          chk("frame_count_step", frame_count, 16'(exp_fc));
          pending_fc = 1'b0;
        end
        if (mr_valid && mr_ready) begin
          if (res_q.size() == 0) chk("result_unexpected", 1'b1, 1'b0);
          else chk("result_beat", {mr_last, mr_data}, res_q.pop_front());
          if (mr_last) begin
            exp_fc++;
            pending_fc = 1'b1;
          end
        end
        if (pw_check) chk("temp_ready_gated", t_ready & ~p_valid, 1'b0);
        if (stall_check && busy) chk("res_ready_follow", sr_ready, mr_ready);
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    axi_resetn = 1'b0; start = 1'b0; abort = 1'b0; num_frames = 16'd0;
    src_on = 1'b1; t_idx = 0; p_idx = 0; jc = 0; pc = 0; r_idx = 0; cyc_n = 0;
    done_cnt = 0; pending_fc = 1'b0;
    drive();
    sr_valid = 1'b1;
    #12;
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset_frame_count", frame_count, 16'd0);
    chk("reset_handshakes", {t_ready, p_ready, sr_ready, j_valid, mr_valid, mr_last}, 6'd0);
    @(negedge aclk); axi_resetn = 1'b1;
    @(negedge aclk);
    chk("idle_handshakes", {t_ready, p_ready, sr_ready, j_valid, mr_valid, busy}, 6'd0);
    @(posedge aclk); #1;
    drive();

    // Two frames, free-flowing streams.
    start_job(2);
    wait_done(400);
    chk("done_after_last_beat", done_cyc - last_beat_cyc, 1);
    end_job_checks("two_frames", 2);

    // Power valid toggling every cycle.
    pw_toggle = 1'b1; pw_check = 1'b1;
    start_job(1);
    wait_done(400);
    chk("joins_eq_power", jc, pc);
    pw_check = 1'b0; pw_toggle = 1'b0;
    end_job_checks("power_toggle", 1);

    // Result sink stalls for five cycles mid-frame.
    stall_beat = 1; stall_left = 5; stall_check = 1'b1;
    start_job(1);
    wait_done(400);
    chk("stall_consumed", stall_left, 0);
    stall_check = 1'b0; stall_beat = -1;
    end_job_checks("result_stall", 1);

    // Zero-frame job.
    done_cnt0 = done_cnt;
    num_frames = 16'd0; start = 1'b1;
    step();
    step();
    chk("zero_done", snap_done, 1'b1);
    chk("zero_no_handshake", {snap_rdy, snap_vld, snap_busy}, 3'd0);
    chk("zero_frame_count", snap_fc, 16'd0);
    step();
    chk("zero_done_width", snap_done, 1'b0);
    chk("zero_done_pulses", done_cnt - done_cnt0, 1);

    // Abort after seven joins of frame 0.
    start_job(1);
    n = 0;
    while (jc < 7 && n < 200) begin step(); n++; end
    chk("abort_reached_7", jc, 7);
    abort = 1'b1; src_on = 1'b0;
    drive();
    step();
    step();
    chk("abort_idle", {snap_busy, snap_done}, 2'b00);
    chk("abort_no_done", done_cnt - done_cnt0, 0);
    chk("abort_join_left", join_q.size(), 9);
    chk("abort_res_left", res_q.size(), 3);
    join_q.delete(); res_q.delete();
    src_on = 1'b1;
    start_job(1);
    wait_done(400);
    end_job_checks("after_abort", 1);

    // Asynchronous reset while draining.
    hold_rready0 = 1'b1;
    start_job(1);
    n = 0;
    while (jc < 16 && n < 200) begin step(); n++; end
    step();
    chk("in_drain", {snap_busy, (jc == 16)}, 2'b11);
    #2 axi_resetn = 1'b0;
    #1;
    chk("async_rst_state", {busy, done}, 2'b00);
    chk("async_rst_frame_count", frame_count, 16'd0);
    chk("async_rst_handshakes", {t_ready, p_ready, sr_ready, j_valid, mr_valid, mr_last}, 6'd0);
    join_q.delete(); res_q.delete();
    pending_fc = 1'b0; hold_rready0 = 1'b0;
    @(negedge aclk); axi_resetn = 1'b1;
    start_job(1);
    step();
    chk("start_first_edge", snap_busy, 1'b1);
    wait_done(400);
    end_job_checks("after_reset", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
